// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller:
// register offsets, FSM state encoding and default vector spacing.
package irq_ctrl_pkg;

    localparam logic [7:0] OFF_IER = 8'd0;
    localparam logic [7:0] OFF_IPR = 8'd1;
    localparam logic [7:0] OFF_ITR = 8'd2;
    localparam logic [7:0] OFF_VBL = 8'd3;
    localparam logic [7:0] OFF_VBH = 8'd4;
    localparam logic [7:0] OFF_ISR = 8'd5;
    localparam logic [7:0] NUM_REGS = 8'd6;

    localparam int VEC_STEP_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_ctrl_pri_enc8.sv
// Combinational lowest-set-bit priority encoder.
// Bit 0 has the highest priority.
module pri_enc8 (
    input  logic [7:0] in,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the lowest priority down so the lowest set bit wins.
    always_comb begin
        idx   = 3'd0;
        valid = |in;
        for (int i = 7; i >= 0; i--) begin
            if (in[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller with an I/O register window,
// edge/level triggering and a vectored request to the CPU.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h30,
    parameter int         VEC_STEP  = VEC_STEP_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [7:0]  io_wdata,
    output logic [7:0]  io_rdata,
    input  logic [7:0]  src,
    output logic        irq,
    output logic [15:0] irq_addr
);

    logic [7:0]  ier;
    logic [7:0]  ipr;
    logic [7:0]  itr;
    logic [7:0]  vbl;
    logic [7:0]  vbh;
    logic [7:0]  src_q;
    logic [2:0]  idx;
    state_t      state;
    state_t      state_nxt;

    logic [7:0]  off;
    logic        hit;
    logic        wr_ier;
    logic        wr_ipr;
    logic        wr_itr;
    logic        wr_vbl;
    logic        wr_vbh;
    logic [7:0]  set_vec;
    logic [7:0]  clr_vec;
    logic [7:0]  ipr_nxt;
    logic [7:0]  ier_nxt;
    logic [7:0]  active;
    logic [2:0]  enc_idx;
    logic        enc_valid;
    logic        load;
    logic [15:0] step_w;
    logic [15:0] vec_addr;

    assign off    = io_addr - BASE_ADDR;
    assign hit    = (off < NUM_REGS);
    assign wr_ier = io_we && hit && (off == OFF_IER);
    assign wr_ipr = io_we && hit && (off == OFF_IPR);
    assign wr_itr = io_we && hit && (off == OFF_ITR);
    assign wr_vbl = io_we && hit && (off == OFF_VBL);
    assign wr_vbh = io_we && hit && (off == OFF_VBH);

    // Edge-mode bits see only 0->1 transitions; level-mode bits see src high.
    assign set_vec = (itr & src & ~src_q) | (~itr & src);
    assign clr_vec = wr_ipr ? io_wdata : 8'h00;
    assign ipr_nxt = (ipr & ~clr_vec) | set_vec;
    assign ier_nxt = wr_ier ? io_wdata : ier;

    assign active = ipr & ier;

    pri_enc8 u_pri_enc8 (
        .in    (active),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign step_w   = 16'(VEC_STEP);
    assign vec_addr = {vbh, vbl} + step_w * {13'd0, enc_idx};

    assign irq = (state == ST_REQ);

    // Configuration and pending registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ier   <= 8'h00;
            ipr   <= 8'h00;
            itr   <= 8'h00;
            vbl   <= 8'h00;
            vbh   <= 8'h00;
            src_q <= 8'h00;
        end else begin
            ier   <= ier_nxt;
            ipr   <= ipr_nxt;
            src_q <= src;
            if (wr_itr) itr <= io_wdata;
            if (wr_vbl) vbl <= io_wdata;
            if (wr_vbh) vbh <= io_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the exit from REQ looks at next-cycle pending/enable.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_nxt = ST_REQ;
                    load      = 1'b1;
                end
            end
            ST_REQ: begin
                if (!ipr_nxt[idx] || !ier_nxt[idx]) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the serviced index and its vector when a request starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= 3'd0;
            irq_addr <= 16'h0000;
        end else if (load) begin
            idx      <= enc_idx;
            irq_addr <= vec_addr;
        end
    end

    // Combinational read mux; reads never change state.
    always_comb begin
        io_rdata = 8'h00;
        if (io_re && hit) begin
            unique case (off)
                OFF_IER: io_rdata = ier;
                OFF_IPR: io_rdata = ipr;
                OFF_ITR: io_rdata = itr;
                OFF_VBL: io_rdata = vbl;
                OFF_VBH: io_rdata = vbh;
                OFF_ISR: io_rdata = irq ? {1'b1, 4'b0000, idx} : 8'h00;
                default: io_rdata = 8'h00;
            endcase
        end
    end

endmodule
